// File: rtl/rank_order_decoder_if.sv
// Rank-order spike event bus between the image sorter (master) and the decoder (slave).
interface rank_order_decoder_if #(
  parameter int IMAGE_SIZE_BITS = 8
);
  logic [IMAGE_SIZE_BITS+1:0] NEXT_INDEX;
  logic                       FOUND_NEXT_INDEX;
  logic                       IMAGE_ENCODED;
  logic                       AERIN_CTRL_BUSY;

  modport master (
    output NEXT_INDEX, FOUND_NEXT_INDEX, IMAGE_ENCODED,
    input  AERIN_CTRL_BUSY
  );

  modport slave (
    input  NEXT_INDEX, FOUND_NEXT_INDEX, IMAGE_ENCODED,
    output AERIN_CTRL_BUSY
  );
endinterface

// File: rtl/rank_order_decoder.sv
// Rank-order spike stream receiver: two-marker frame sync, per-pixel arrival rank map, AER busy back-pressure.
// Optional duplicate-index detection is enabled by defining RANK_DECODER_DUP_CHECK_EN.
module rank_order_decoder #(
  parameter int IMAGE_SIZE      = 256,
  parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
  parameter int BUSY_CYCLES     = 3,
  parameter logic [IMAGE_SIZE_BITS+1:0] MARKER_CODE = {1'b0, 1'b1, {IMAGE_SIZE_BITS{1'b1}}}
) (
  input  logic                       CLK,
  input  logic                       RST,
  rank_order_decoder_if.slave        aer,
  output logic [IMAGE_SIZE_BITS:0]   RANK_MAP [IMAGE_SIZE],
  output logic [IMAGE_SIZE_BITS:0]   PIXEL_COUNT,
  output logic                       FRAME_ACTIVE,
  output logic                       FRAME_DONE,
  output logic                       ERR_OVERRUN,
`ifdef RANK_DECODER_DUP_CHECK_EN
  output logic                       ERR_DUPLICATE,
`endif
  output logic                       ERR_RANGE
);
  localparam logic [IMAGE_SIZE_BITS:0] SIZE_W    = IMAGE_SIZE[IMAGE_SIZE_BITS:0];
  localparam logic [3:0]               BUSY_INIT = BUSY_CYCLES[3:0];

  typedef enum logic [1:0] {IDLE, SYNC, RECEIVE, DONE} state_t;

  state_t                     state_q, state_d;
  logic [IMAGE_SIZE_BITS:0]   rank_map_q [IMAGE_SIZE];
  logic [IMAGE_SIZE_BITS:0]   rank_map_d [IMAGE_SIZE];
  logic [IMAGE_SIZE_BITS:0]   pixel_count_q, pixel_count_d;
  logic [3:0]                 busy_cnt_q, busy_cnt_d;
  logic                       busy_q, busy_d;
  logic                       err_overrun_q, err_overrun_d;
  logic                       err_range_q, err_range_d;
`ifdef RANK_DECODER_DUP_CHECK_EN
  logic [IMAGE_SIZE-1:0]      seen_q, seen_d;
  logic                       err_dup_q, err_dup_d;
`endif

  logic                       accept;
  logic                       is_marker;
  logic                       in_range;
  logic [IMAGE_SIZE_BITS-1:0] idx;

  assign accept    = aer.FOUND_NEXT_INDEX && !busy_q;
  assign is_marker = (aer.NEXT_INDEX == MARKER_CODE);
  assign in_range  = (aer.NEXT_INDEX < {1'b0, SIZE_W});
  assign idx       = aer.NEXT_INDEX[IMAGE_SIZE_BITS-1:0];

  always_comb begin
    state_d       = state_q;
    rank_map_d    = rank_map_q;
    pixel_count_d = pixel_count_q;
    err_overrun_d = err_overrun_q;
    err_range_d   = err_range_q;
`ifdef RANK_DECODER_DUP_CHECK_EN
    seen_d        = seen_q;
    err_dup_d     = err_dup_q;
`endif

    // Busy counter reloads on acceptance; BUSY is its registered non-zero flag.
    if (accept)                busy_cnt_d = BUSY_INIT;
    else if (busy_cnt_q != '0) busy_cnt_d = busy_cnt_q - 4'd1;
    else                       busy_cnt_d = '0;
    busy_d = (busy_cnt_d != '0);

    if (aer.FOUND_NEXT_INDEX && busy_q) err_overrun_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (accept && is_marker) state_d = SYNC;
      end
      SYNC: begin
        if (accept) begin
          if (is_marker) begin
            for (int i = 0; i < IMAGE_SIZE; i++) rank_map_d[i] = SIZE_W;
            pixel_count_d = '0;
            err_overrun_d = 1'b0;
            err_range_d   = 1'b0;
`ifdef RANK_DECODER_DUP_CHECK_EN
            seen_d        = '0;
            err_dup_d     = 1'b0;
`endif
            state_d = RECEIVE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      RECEIVE: begin
        if (pixel_count_q == SIZE_W) begin
          state_d = DONE;
        end else begin
          if (accept) begin
            if (in_range) begin
`ifdef RANK_DECODER_DUP_CHECK_EN
              if (seen_q[idx]) begin
                err_dup_d = 1'b1;
              end else begin
                seen_d[idx]     = 1'b1;
                rank_map_d[idx] = pixel_count_q;
                pixel_count_d   = pixel_count_q + 1'b1;
              end
`else
              rank_map_d[idx] = pixel_count_q;
              pixel_count_d   = pixel_count_q + 1'b1;
`endif
            end else if (!is_marker) begin
              err_range_d = 1'b1;
            end
          end
          if (aer.IMAGE_ENCODED) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= IDLE;
      for (int i = 0; i < IMAGE_SIZE; i++) rank_map_q[i] <= SIZE_W;
      pixel_count_q <= '0;
      busy_cnt_q    <= '0;
      busy_q        <= 1'b0;
      err_overrun_q <= 1'b0;
      err_range_q   <= 1'b0;
`ifdef RANK_DECODER_DUP_CHECK_EN
      seen_q        <= '0;
      err_dup_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      rank_map_q    <= rank_map_d;
      pixel_count_q <= pixel_count_d;
      busy_cnt_q    <= busy_cnt_d;
      busy_q        <= busy_d;
      err_overrun_q <= err_overrun_d;
      err_range_q   <= err_range_d;
`ifdef RANK_DECODER_DUP_CHECK_EN
      seen_q        <= seen_d;
      err_dup_q     <= err_dup_d;
`endif
    end
  end

  assign RANK_MAP            = rank_map_q;
  assign PIXEL_COUNT         = pixel_count_q;
  assign FRAME_ACTIVE        = (state_q == RECEIVE);
  assign FRAME_DONE          = (state_q == DONE);
  assign ERR_OVERRUN         = err_overrun_q;
  assign ERR_RANGE           = err_range_q;
  assign aer.AERIN_CTRL_BUSY = busy_q;
`ifdef RANK_DECODER_DUP_CHECK_EN
  assign ERR_DUPLICATE       = err_dup_q;
`endif
endmodule

// File: tb/tb_rank_order_decoder.sv
// Directed self-checking bench for rank_order_decoder (default 256-pixel configuration).
module tb_rank_order_decoder;
  localparam logic [9:0] MARK = 10'h1FF;

  logic       clk;
  logic       rst;
  logic [8:0] rank_map [256];
  logic [8:0] pixel_count;
  logic       frame_active, frame_done, err_overrun, err_range;
`ifdef RANK_DECODER_DUP_CHECK_EN
  logic       err_duplicate;
`endif
  int total = 0;
  int fails = 0;

  rank_order_decoder_if #(.IMAGE_SIZE_BITS(8)) aer ();

  rank_order_decoder dut (
    .CLK          (clk),
    .RST          (rst),
    .aer          (aer.slave),
    .RANK_MAP     (rank_map),
    .PIXEL_COUNT  (pixel_count),
    .FRAME_ACTIVE (frame_active),
    .FRAME_DONE   (frame_done),
    .ERR_OVERRUN  (err_overrun),
`ifdef RANK_DECODER_DUP_CHECK_EN
    .ERR_DUPLICATE(err_duplicate),
`endif
    .ERR_RANGE    (err_range)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Waits (bounded) for BUSY low, then strobes one event for a single cycle.
  task automatic send(input logic [9:0] code, input logic ie);
    int n = 0;
    while (aer.AERIN_CTRL_BUSY === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      total++;
      fails++;
      $error("FAIL busy_timeout: observed busy after %0d cycles expected low", n);
    end
    aer.NEXT_INDEX       = code;
    aer.FOUND_NEXT_INDEX = 1'b1;
    aer.IMAGE_ENCODED    = ie;
    tick();
    aer.FOUND_NEXT_INDEX = 1'b0;
    aer.IMAGE_ENCODED    = 1'b0;
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (aer.AERIN_CTRL_BUSY === 1'b1 && n < 20) begin
      n++;
      tick();
    end
  endtask

  function automatic int map_not_empty();
    int c = 0;
    for (int i = 0; i < 256; i++) if (rank_map[i] !== 9'd256) c++;
    return c;
  endfunction

  initial begin
    int n;
    int bad;
    rst                  = 1'b1;
    aer.NEXT_INDEX       = '0;
    aer.FOUND_NEXT_INDEX = 1'b0;
    aer.IMAGE_ENCODED    = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_busy", aer.AERIN_CTRL_BUSY, 0);
    check("rst_active", frame_active, 0);
    check("rst_done", frame_done, 0);
    check("rst_count", pixel_count, 0);
    check("rst_errs", {err_overrun, err_range}, 0);
    check("rst_map", map_not_empty(), 0);
    rst = 1'b0;
    tick();

    // IMAGE_ENCODED while idle is ignored
    aer.IMAGE_ENCODED = 1'b1;
    tick();
    aer.IMAGE_ENCODED = 1'b0;
    check("idle_ie_done", frame_done, 0);
    tick();
    check("idle_ie_done2", frame_done, 0);

    // Frame start: two markers, busy exactly 3 cycles each
    send(MARK, 1'b0);
    check("sync1_active", frame_active, 0);
    busy_len(n);
    check("sync1_busy_len", n, 3);
    send(MARK, 1'b0);
    check("sync2_active", frame_active, 1);
    check("sync2_count", pixel_count, 0);
    check("sync2_map", map_not_empty(), 0);
    busy_len(n);
    check("sync2_busy_len", n, 3);

    // Full frame: 255 down to 0
    for (int i = 255; i >= 0; i--) send(10'(i), 1'b0);
    check("full_count", pixel_count, 256);
    n = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (frame_done === 1'b1) n++;
    end
    check("full_done_pulses", n, 1);
    check("full_active", frame_active, 0);
    check("full_map255", rank_map[255], 0);
    check("full_map0", rank_map[0], 255);
    bad = 0;
    for (int i = 0; i < 256; i++) if (rank_map[i] !== 9'(255 - i)) bad++;
    check("full_map_all", bad, 0);
    check("full_count_hold", pixel_count, 256);

    // Early end via IMAGE_ENCODED
    send(MARK, 1'b0);
    send(MARK, 1'b0);
    send(10'd7, 1'b0);
    send(10'd3, 1'b0);
    aer.IMAGE_ENCODED = 1'b1;
    tick();
    aer.IMAGE_ENCODED = 1'b0;
    check("early_done", frame_done, 1);
    tick();
    check("early_done_drop", frame_done, 0);
    check("early_active", frame_active, 0);
    check("early_map7", rank_map[7], 0);
    check("early_map3", rank_map[3], 1);
    check("early_map_others", map_not_empty(), 2);
    check("early_count", pixel_count, 2);

    // Overrun, range error, mid-frame marker, pixel with simultaneous end
    send(MARK, 1'b0);
    send(MARK, 1'b0);
    send(10'd20, 1'b0);
    aer.NEXT_INDEX       = 10'd5;
    aer.FOUND_NEXT_INDEX = 1'b1;
    tick();
    aer.FOUND_NEXT_INDEX = 1'b0;
    check("ovr_flag", err_overrun, 1);
    check("ovr_map5", rank_map[5], 256);
    check("ovr_count", pixel_count, 1);
    send(10'h200, 1'b0);
    check("range_flag", err_range, 1);
    check("range_count", pixel_count, 1);
    send(MARK, 1'b0);
    check("midmark_active", frame_active, 1);
    check("midmark_count", pixel_count, 1);
    send(10'd5, 1'b1);
    check("simul_map5", rank_map[5], 1);
    check("simul_count", pixel_count, 2);
    check("simul_done", frame_done, 1);
    check("simul_ovr_sticky", err_overrun, 1);
    tick();

    // Broken sync stays out of frame; a further marker starts it
    send(MARK, 1'b0);
    send(10'h010, 1'b0);
    send(MARK, 1'b0);
    check("broken_active", frame_active, 0);
    check("broken_map_hold", rank_map[5], 1);
    send(MARK, 1'b0);
    check("resync_active", frame_active, 1);
    check("resync_errs", {err_overrun, err_range}, 0);
    check("resync_map5", rank_map[5], 256);

    // Duplicate index
    send(10'd9, 1'b0);
    send(10'd9, 1'b0);
`ifdef RANK_DECODER_DUP_CHECK_EN
    check("dup_map9", rank_map[9], 0);
    check("dup_count", pixel_count, 1);
    check("dup_flag", err_duplicate, 1);
`else
    check("dup_map9", rank_map[9], 1);
    check("dup_count", pixel_count, 2);
`endif

    // Reset mid-frame
    rst = 1'b1;
    tick();
    check("mrst_active", frame_active, 0);
    check("mrst_count", pixel_count, 0);
    check("mrst_busy", aer.AERIN_CTRL_BUSY, 0);
    check("mrst_errs", {err_overrun, err_range}, 0);
    check("mrst_map", map_not_empty(), 0);
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/rank_order_decoder.md
Name: rank_order_decoder

Overview:
- Receiving end of the rank-order spike stream produced by the image sorter.
- Consumes index events (FOUND_NEXT_INDEX strobe + NEXT_INDEX) and applies AER-style back-pressure through AERIN_CTRL_BUSY.
- Detects the two-event frame-start marker and records the arrival rank of every pixel into a rank map.
- Flags frame completion, and flags protocol errors for testbench self-checking and on-chip loopback.

Parameters:
- IMAGE_SIZE, 256, pixels per frame.
- IMAGE_SIZE_BITS, $clog2(IMAGE_SIZE), pixel index width.
- BUSY_CYCLES, 3, cycles AERIN_CTRL_BUSY stays high per accepted event (range 1..15).
- MARKER_CODE, {1'b0,1'b1,{IMAGE_SIZE_BITS{1'b1}}}, reset/marker event code (0x1FF at defaults).

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, asynchronous, active-high.
- NEXT_INDEX  in  IMAGE_SIZE_BITS+2  event code; sampled only when FOUND_NEXT_INDEX=1.
- FOUND_NEXT_INDEX  in  1  one-cycle event strobe.
- IMAGE_ENCODED  in  1  one-cycle end-of-frame strobe from the sender.
- AERIN_CTRL_BUSY  out  1  back-pressure to the sender; registered.
- RANK_MAP  out  [IMAGE_SIZE_BITS:0] x IMAGE_SIZE  per-pixel arrival rank; IMAGE_SIZE means "not received".
- PIXEL_COUNT  out  IMAGE_SIZE_BITS+1  pixel events accepted in the current frame.
- FRAME_ACTIVE  out  1  high between frame start and frame end.
- FRAME_DONE  out  1  one-cycle pulse at frame end.
- ERR_OVERRUN  out  1  sticky: strobe arrived while BUSY was high.
- ERR_RANGE  out  1  sticky: non-marker index >= IMAGE_SIZE.

Behaviour:
- Reset:
  - All outputs 0, except every RANK_MAP entry = IMAGE_SIZE.
  - marker_cnt = 0, busy counter = 0, state = IDLE.
- Back-pressure:
  - Every strobe sampled while BUSY=0 is accepted.
  - AERIN_CTRL_BUSY rises the cycle after an accepted strobe and stays high exactly BUSY_CYCLES cycles, then falls.
- Overrun: a strobe while BUSY=1 is dropped (no state or map change) and sets ERR_OVERRUN.
- States:
  - IDLE: an accepted MARKER_CODE sets marker_cnt=1 and moves to SYNC. Non-marker events are ignored; no error.
  - SYNC: an accepted MARKER_CODE means frame start:
    - clear all RANK_MAP entries to IMAGE_SIZE;
    - clear PIXEL_COUNT and the sticky errors;
    - assert FRAME_ACTIVE and move to RECEIVE.
  - SYNC: any accepted non-marker event returns to IDLE with marker_cnt=0.
  - RECEIVE: an accepted index i < IMAGE_SIZE writes RANK_MAP[i] <= PIXEL_COUNT, and PIXEL_COUNT increments (write and increment in the same cycle).
  - RECEIVE: an accepted index >= IMAGE_SIZE that is not MARKER_CODE sets ERR_RANGE; map and count unchanged.
  - RECEIVE: an accepted MARKER_CODE is ignored; it is a mid-frame resync request and is handled in IDLE only.
  - RECEIVE exit, whichever occurs first:
    - PIXEL_COUNT reaches IMAGE_SIZE (detected the cycle after the final write);
    - IMAGE_ENCODED=1.
  - RECEIVE exit action: go to DONE.
  - DONE: pulse FRAME_DONE for one cycle, drop FRAME_ACTIVE, go to IDLE. RANK_MAP and PIXEL_COUNT hold until the next frame start.
- Simultaneous events:
  - IMAGE_ENCODED with an accepted pixel strobe in the same cycle: the pixel is written first, then the frame ends.
  - IMAGE_ENCODED outside RECEIVE is ignored.
- Widths: PIXEL_COUNT saturates at IMAGE_SIZE; no wrap.
- Reset mid-frame returns everything to reset values immediately.

Optional Feature:
- Macro: RANK_DECODER_DUP_CHECK_EN.
- Enabled:
  - adds an IMAGE_SIZE-bit seen-mask, cleared at frame start;
  - adds output ERR_DUPLICATE (sticky, cleared at frame start);
  - in RECEIVE, an accepted index whose mask bit is set does not overwrite RANK_MAP, does not increment PIXEL_COUNT, and sets ERR_DUPLICATE.
- Disabled: no mask and no port; a duplicate overwrites the rank and counts as a new pixel.

Test Plan:
- Frame start: strobe 0x1FF twice, each after BUSY falls -> BUSY high 3 cycles after each strobe; FRAME_ACTIVE=1 after the second; PIXEL_COUNT=0; all RANK_MAP=256.
- Full frame: after sync, send indices 255 down to 0 -> RANK_MAP[255]=0, RANK_MAP[0]=255, PIXEL_COUNT=256, one FRAME_DONE pulse, FRAME_ACTIVE=0.
- Early end: after sync, send 7 then 3, then pulse IMAGE_ENCODED -> RANK_MAP[7]=0, RANK_MAP[3]=1, others 256, FRAME_DONE pulses, PIXEL_COUNT=2.
- Overrun/range: strobe index 5 on the cycle after an accepted event -> dropped, ERR_OVERRUN=1. Strobe 0x200 -> ERR_RANGE=1, PIXEL_COUNT unchanged.
- Broken sync: 0x1FF, then 0x010, then 0x1FF -> remains not active (IDLE/SYNC); a further 0x1FF starts the frame.
- With RANK_DECODER_DUP_CHECK_EN: send 9, 9 -> RANK_MAP[9]=0, PIXEL_COUNT=1, ERR_DUPLICATE=1. Without it -> RANK_MAP[9]=1, PIXEL_COUNT=2. Assert RST mid-frame -> all reset values next cycle.
